// File: rtl/load_store_unit.sv
// Load/store unit: alignment check, one memory handshake per access, store lane
// formation and load extraction. Define LSU_TIMEOUT_EN to build the BUSY watchdog.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken when req_valid is high while req_ready is
  // high (IDLE); the memory side holds mem_req until the cycle mem_ack is high.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        legal, mis_req, accept, go_busy, timeout_hit;
  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt;
  logic [2:0]  func3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] shifted, ext_data;

  assign accept    = (state == IDLE) && req_valid;
  assign go_busy   = legal && !mis_req;
  assign stall     = req_valid & ~resp_valid;
  assign dbg_state = state;

  // Request decode on the live inputs; only meaningful while accepting.
  always_comb begin
    legal = req_we ? (!func3[2] && (func3[1:0] != 2'b11))
                   : ((func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111));
    mis_req = legal && (((func3[1:0] == 2'b01) && alu_out[0]) ||
                        ((func3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00)));
    wstrb_nxt = 4'b0000;
    wdata_nxt = 32'h0;
    if (req_we) begin
      unique case (func3[1:0])
        2'b00:   begin wstrb_nxt = 4'b0001 << alu_out[1:0];
                       wdata_nxt = {4{store_data[7:0]}}; end
        2'b01:   begin wstrb_nxt = 4'b0011 << {alu_out[1], 1'b0};
                       wdata_nxt = {2{store_data[15:0]}}; end
        default: begin wstrb_nxt = 4'b1111;
                       wdata_nxt = store_data; end
      endcase
    end
  end

  // Load extraction from the latched address offset and func3.
  always_comb begin
    shifted = mem_rdata >> {addr_lo_q, 3'b000};
    unique case (func3_q)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ext_data = mem_rdata;
      3'b100:  ext_data = {24'h0, shifted[7:0]};
      3'b101:  ext_data = {16'h0, shifted[15:0]};
      default: ext_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = go_busy ? BUSY : RESP;
      BUSY:    if (mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_req    = (state == BUSY);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func3_q   <= 3'b000;
      addr_lo_q <= 2'b00;
      load_data <= 32'h0;
      misalign  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      misalign <= accept && mis_req;
      if (accept) begin
        func3_q   <= func3;
        addr_lo_q <= alu_out[1:0];
        load_data <= 32'h0;
        if (go_busy) begin
          mem_addr  <= {alu_out[31:2], 2'b00};
          mem_we    <= req_we;
          mem_wstrb <= wstrb_nxt;
          mem_wdata <= wdata_nxt;
        end
      end else if ((state == BUSY) && mem_ack && !mem_we) begin
        load_data <= ext_data;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] to_cnt;

  // An ack in the same cycle as the limit wins over the abort.
  assign timeout_hit = (state == BUSY) && !mem_ack && (to_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= 8'h0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout_hit;
      if (accept)                         to_cnt <= 8'h0;
      else if (state == BUSY && !mem_ack) to_cnt <= to_cnt + 8'h1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

endmodule
